csa_resolver: RTL and testbench

CSA_RESOLVER -- requirements
Module: csa_resolver

---
 rtl/csa_resolver.sv | 99 +++++++++
 tb/tb_csa_resolver.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/csa_resolver.sv
// Carry-save to binary resolver: adds one 8-bit slice of sum + 2*carry per cycle.
// Optional macro CSA_RESOLVE_HI_EN keeps operand bit 32 and exposes V[33:32] on result_hi.
module csa_resolver (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] sum_in,
    input  logic [31:0] carry_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result_out
`ifdef CSA_RESOLVE_HI_EN
   ,output logic [1:0]  result_hi
`endif
);

`ifdef CSA_RESOLVE_HI_EN
    localparam int OPW = 33;
`else
    localparam int OPW = 32;
`endif
    localparam int IW = $clog2(OPW);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nx;
    logic [OPW-1:0] op_a, op_b;
    logic [1:0]     cnt;
    logic           carry;
    logic [4:0]     rpos;
    logic [IW-1:0]  idx;
    logic [8:0]     slice_sum;

    assign rpos      = {cnt, 3'b000};
    assign idx       = IW'(rpos);
    assign slice_sum = {1'b0, op_a[idx +: 8]} + {1'b0, op_b[idx +: 8]} + {8'd0, carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN:  if (cnt == 2'd3) state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            result_out <= '0;
`ifdef CSA_RESOLVE_HI_EN
            result_hi  <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    // Without the high bits, carry_in[31] shifts out and is never stored.
                    op_a       <= OPW'(sum_in);
                    op_b       <= OPW'({carry_in, 1'b0});
                    cnt        <= '0;
                    carry      <= 1'b0;
                    result_out <= '0;
`ifdef CSA_RESOLVE_HI_EN
                    result_hi  <= '0;
`endif
                end
                RUN: begin
                    result_out[rpos +: 8] <= slice_sum[7:0];
                    carry                 <= slice_sum[8];
                    cnt                   <= cnt + 2'd1;
`ifdef CSA_RESOLVE_HI_EN
                    if (cnt == 2'd3)
                        result_hi <= {1'b0, slice_sum[8]} + {1'b0, op_a[32]} + {1'b0, op_b[32]};
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_resolver.sv
// Scoreboard bench for csa_resolver: driver pushes expected V per accept, monitor checks on out_valid.
module tb_csa_resolver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] sum_in = '0;
    logic [31:0] carry_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result_out;
`ifdef CSA_RESOLVE_HI_EN
    logic [1:0]  result_hi;
`endif

    csa_resolver dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sum_in(sum_in), .carry_in(carry_in), .out_valid(out_valid),
        .out_ready(out_ready), .result_out(result_out)
`ifdef CSA_RESOLVE_HI_EN
       ,.result_hi(result_hi)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [33:0] v;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: value and latency on the rising out_valid, stability while held.
    logic        prev_valid = 1'b0;
    logic [33:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 34'd1, 34'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result_out", {2'b0, result_out}, {2'b0, e.v[31:0]});
`ifdef CSA_RESOLVE_HI_EN
                    chk("result_hi", {32'd0, result_hi}, {32'd0, e.v[33:32]});
`endif
                    chk("latency", 34'(cyc - e.acc), 34'd4);
                end
                held = {2'b0, result_out};
`ifdef CSA_RESOLVE_HI_EN
                held[33:32] = result_hi;
`endif
            end else if (out_valid && prev_valid) begin
`ifdef CSA_RESOLVE_HI_EN
                chk("held_stable", {result_hi, result_out}, held);
`else
                chk("held_stable", {2'b0, result_out}, held);
`endif
            end
            prev_valid = out_valid;
        end
    end

    task automatic wait_ready(output bit ok);
        int w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        ok = in_ready;
        if (!ok) chk("wait_in_ready_timeout", 34'd0, 34'd1);
    endtask

    // One transaction; inputs keep toggling with in_valid=1 while busy and must be ignored.
    task automatic send(input logic [31:0] s, input logic [31:0] c, input bit bp);
        bit   ok;
        int   w;
        exp_t e;
        wait_ready(ok);
        if (!ok) return;
        out_ready = bp ? 1'b0 : 1'b1;
        in_valid  = 1'b1;
        sum_in    = s;
        carry_in  = c;
        e.v   = {2'b0, s} + ({2'b0, c} << 1);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        w = 0;
        while (!out_valid && w < 10) begin
            sum_in   = $urandom;
            carry_in = $urandom;
            chk("in_ready_busy", {33'd0, in_ready}, 34'd0);
            @(negedge clk);
            w++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 34'd0, 34'd1);
            in_valid = 1'b0;
            return;
        end
        if (bp) begin
            for (int i = 0; i < 10; i++) begin
                sum_in   = $urandom;
                carry_in = $urandom;
                chk("in_ready_bp", {33'd0, in_ready}, 34'd0);
                @(negedge clk);
            end
            out_ready = 1'b1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_after_done", {33'd0, in_ready}, 34'd1);
        chk("out_valid_after_done", {33'd0, out_valid}, 34'd0);
    endtask

    initial begin
        bit ok;
        int w;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {33'd0, out_valid}, 34'd0);
        chk("rst_result_out", {2'b0, result_out}, 34'd0);
`ifdef CSA_RESOLVE_HI_EN
        chk("rst_result_hi", {32'd0, result_hi}, 34'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {33'd0, in_ready}, 34'd1);

        send(32'h0000_0005, 32'h0000_0003, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        send(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        send($urandom, $urandom, 1'b1);

        // Reset two cycles into a resolution must leave nothing behind.
        wait_ready(ok);
        if (ok) begin
            in_valid = 1'b1;
            sum_in   = 32'hDEAD_BEEF;
            carry_in = 32'h1234_5678;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("midrun_rst_out_valid", {33'd0, out_valid}, 34'd0);
            chk("midrun_rst_result_out", {2'b0, result_out}, 34'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("midrun_rst_in_ready", {33'd0, in_ready}, 34'd1);
            repeat (6) @(negedge clk);
            chk("midrun_no_output", {33'd0, out_valid}, 34'd0);
        end

        for (int i = 0; i < 40; i++)
            send($urandom, $urandom, ($urandom_range(0, 7) == 0));

        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) chk("scoreboard_drain", 34'(exp_q.size()), 34'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
